// File: rtl/riscv_uart_programmer.sv
// riscv_uart_programmer
//   UART bootloader master. Receives an 8N1 byte stream from a host, parses a
//   session header (command byte + 16-bit little-endian word count), assembles
//   little-endian 32-bit words and writes them through the UPG port of the
//   instruction/data RAM wrappers.
// Ports:
//   clk         UPG clock, all logic on posedge
//   rst         synchronous active-low reset
//   rx          asynchronous UART line, idle high
//   upg_rst_o   1 = no session in progress, 0 = programming session active
//   upg_wen_o   one-cycle write strobe per assembled word
//   upg_adr_o   [14] target (0 = instr RAM, 1 = data RAM), [13:0] word address
//   upg_dat_o   write data, held until the next strobe
//   upg_done_o  sticky, set together with the last word's strobe
//   err_o       sticky, framing error or bad command byte seen
module riscv_uart_programmer #(
  parameter int CLKS_PER_BIT = 87,
  parameter int SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic        upg_rst_o,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TICK = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [2:0] {HDR_CMD, HDR_LEN0, HDR_LEN1, DATA, DONE} ses_state_t;

  logic [SYNC_STAGES-1:0] r_rx_sync;
  logic                   r_rx_prev;
  logic                   w_rx;

  rx_state_t              r_rx_state;
  logic [CW-1:0]          r_clk_cnt;
  logic [2:0]             r_bit_idx;
  logic [7:0]             r_shift;
  logic                   r_byte_vld;
  logic [7:0]             r_byte;
  logic                   r_frame_err;

  ses_state_t             r_state;
  logic                   r_tgt;
  logic [7:0]             r_len_lo;
  logic [15:0]            r_words_left;
  logic [23:0]            r_word;
  logic [1:0]             r_byte_idx;
  logic [13:0]            r_adr;
  logic                   r_upg_rst;
  logic                   r_upg_wen;
  logic [14:0]            r_upg_adr;
  logic [31:0]            r_upg_dat;
  logic                   r_upg_done;
  logic                   r_err;

  assign w_rx       = r_rx_sync[SYNC_STAGES-1];
  assign upg_rst_o  = r_upg_rst;
  assign upg_wen_o  = r_upg_wen;
  assign upg_adr_o  = r_upg_adr;
  assign upg_dat_o  = r_upg_dat;
  assign upg_done_o = r_upg_done;
  assign err_o      = r_err;

  // Synchronise the asynchronous rx line; keep one extra stage for edge detect.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_sync <= '1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_sync <= {r_rx_sync[SYNC_STAGES-2:0], rx};
      r_rx_prev <= w_rx;
    end
  end

  // 8N1 receiver: mid-bit sampling, LSB first, one-cycle byte_vld or frame_err pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rx_state  <= RX_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'h00;
      r_byte_vld  <= 1'b0;
      r_byte      <= 8'h00;
      r_frame_err <= 1'b0;
    end else begin
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_clk_cnt <= '0;
          if (r_rx_prev && !w_rx) begin
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_clk_cnt == HALF_TICK) begin
            r_clk_cnt <= '0;
            r_bit_idx <= 3'd0;
            // A glitch that is gone by mid start bit is abandoned silently.
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (r_clk_cnt == LAST_TICK) begin
            r_clk_cnt <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_rx_state <= RX_STOP;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (r_clk_cnt == LAST_TICK) begin
            r_clk_cnt <= '0;
            if (w_rx) begin
              r_byte_vld <= 1'b1;
              r_byte     <= r_shift;
              r_rx_state <= RX_IDLE;
            end else begin
              // Bad stop bit: drop the byte and wait for the line to recover.
              r_frame_err <= 1'b1;
              r_rx_state  <= RX_WAIT;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        RX_WAIT: begin
          r_clk_cnt <= '0;
          if (w_rx) begin
            r_rx_state <= RX_IDLE;
          end
        end
        default: begin
          r_rx_state <= RX_IDLE;
        end
      endcase
    end
  end

  // Session FSM: header parse, word assembly and registered UPG outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= HDR_CMD;
      r_tgt        <= 1'b0;
      r_len_lo     <= 8'h00;
      r_words_left <= 16'h0000;
      r_word       <= 24'h000000;
      r_byte_idx   <= 2'd0;
      r_adr        <= 14'h0000;
      r_upg_rst    <= 1'b1;
      r_upg_wen    <= 1'b0;
      r_upg_adr    <= 15'h0000;
      r_upg_dat    <= 32'h0000_0000;
      r_upg_done   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_upg_wen <= 1'b0;
      if (r_frame_err) begin
        r_err <= 1'b1;
      end
      if (r_byte_vld) begin
        case (r_state)
          HDR_CMD: begin
            if (r_byte == 8'h00 || r_byte == 8'h01) begin
              r_tgt     <= r_byte[0];
              r_upg_rst <= 1'b0;
              r_state   <= HDR_LEN0;
            end else begin
              r_err <= 1'b1;
            end
          end
          HDR_LEN0: begin
            r_len_lo <= r_byte;
            r_state  <= HDR_LEN1;
          end
          HDR_LEN1: begin
            r_words_left <= {r_byte, r_len_lo};
            r_byte_idx   <= 2'd0;
            r_adr        <= 14'h0000;
            if ({r_byte, r_len_lo} == 16'h0000) begin
              r_upg_done <= 1'b1;
              r_state    <= DONE;
            end else begin
              r_state <= DATA;
            end
          end
          DATA: begin
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word[7:0]   <= r_byte;
              2'd1: r_word[15:8]  <= r_byte;
              2'd2: r_word[23:16] <= r_byte;
              default: begin
                r_upg_dat    <= {r_byte, r_word};
                r_upg_adr    <= {r_tgt, r_adr};
                r_upg_wen    <= 1'b1;
                r_adr        <= r_adr + 14'd1;
                r_words_left <= r_words_left - 16'd1;
                // Done rises together with the last word's strobe.
                if (r_words_left == 16'd1) begin
                  r_upg_done <= 1'b1;
                  r_state    <= DONE;
                end
              end
            endcase
          end
          DONE: begin
            r_state <= DONE;
          end
          default: begin
            r_state <= HDR_CMD;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_riscv_uart_programmer.sv
module tb_riscv_uart_programmer;

  localparam int CPB = 8;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        upg_rst_o;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o;
  logic        err_o;

  int checks;
  int failures;

  logic [14:0] q_adr[$];
  logic [31:0] q_dat[$];
  logic        q_done[$];

  riscv_uart_programmer #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .upg_rst_o(upg_rst_o), .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o),
    .upg_dat_o(upg_dat_o), .upg_done_o(upg_done_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every strobe cycle, sampled away from the active edge.
  always @(negedge clk) begin
    if (upg_wen_o === 1'b1) begin
      q_adr.push_back(upg_adr_o);
      q_dat.push_back(upg_dat_o);
      q_done.push_back(upg_done_o);
    end
  end

  task automatic clear_q();
    q_adr.delete();
    q_dat.delete();
    q_done.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB + 4) @(negedge clk);
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_byte(b, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_q();
  endtask

  task automatic test_reset();
    rx = 1'b1;
    do_reset();
    checks++; if (upg_rst_o !== 1'b1) begin failures++; $display("FAIL reset_upg_rst got=%b exp=1", upg_rst_o); end
    checks++; if (upg_wen_o !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", upg_wen_o); end
    checks++; if (upg_adr_o !== 15'h0000) begin failures++; $display("FAIL reset_adr got=%h exp=0000", upg_adr_o); end
    checks++; if (upg_dat_o !== 32'h0) begin failures++; $display("FAIL reset_dat got=%h exp=0", upg_dat_o); end
    checks++; if (upg_done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", upg_done_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
  endtask

  task automatic test_single_word();
    do_reset();
    send_ok(8'h01);
    checks++; if (upg_rst_o !== 1'b0) begin failures++; $display("FAIL t1_rst_after_cmd got=%b exp=0", upg_rst_o); end
    send_ok(8'h01); send_ok(8'h00);
    send_ok(8'hEF); send_ok(8'hBE); send_ok(8'hAD);
    checks++; if (q_adr.size() != 0) begin failures++; $display("FAIL t1_early_strobe got=%0d exp=0", q_adr.size()); end
    send_ok(8'hDE);
    checks++;
    if (q_adr.size() != 1) begin
      failures++; $display("FAIL t1_strobes got=%0d exp=1", q_adr.size());
    end else begin
      checks++; if (q_adr[0] !== 15'h4000) begin failures++; $display("FAIL t1_adr got=%h exp=4000", q_adr[0]); end
      checks++; if (q_dat[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL t1_dat got=%h exp=deadbeef", q_dat[0]); end
      checks++; if (q_done[0] !== 1'b1) begin failures++; $display("FAIL t1_done_with_strobe got=%b exp=1", q_done[0]); end
    end
    checks++; if (upg_done_o !== 1'b1) begin failures++; $display("FAIL t1_done got=%b exp=1", upg_done_o); end
    checks++; if (upg_dat_o !== 32'hDEADBEEF) begin failures++; $display("FAIL t1_dat_hold got=%h exp=deadbeef", upg_dat_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL t1_err got=%b exp=0", err_o); end
  endtask

  task automatic test_multi_word();
    logic [31:0] exp_dat [3];
    exp_dat[0] = 32'h03020100; exp_dat[1] = 32'h07060504; exp_dat[2] = 32'h0B0A0908;
    do_reset();
    send_ok(8'h00); send_ok(8'h03); send_ok(8'h00);
    for (int i = 0; i < 12; i++) send_ok(8'(i));
    send_ok(8'h55); send_ok(8'h66); send_ok(8'h77); send_ok(8'h88);
    checks++;
    if (q_adr.size() != 3) begin
      failures++; $display("FAIL t2_strobes got=%0d exp=3", q_adr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (q_adr[i] !== 15'(i)) begin failures++; $display("FAIL t2_adr%0d got=%h exp=%h", i, q_adr[i], 15'(i)); end
        checks++; if (q_dat[i] !== exp_dat[i]) begin failures++; $display("FAIL t2_dat%0d got=%h exp=%h", i, q_dat[i], exp_dat[i]); end
        checks++; if (q_done[i] !== (i == 2)) begin failures++; $display("FAIL t2_done%0d got=%b exp=%b", i, q_done[i], (i == 2)); end
      end
    end
    checks++; if (upg_done_o !== 1'b1) begin failures++; $display("FAIL t2_done got=%b exp=1", upg_done_o); end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_ok(8'h00); send_ok(8'h00); send_ok(8'h00);
    checks++; if (q_adr.size() != 0) begin failures++; $display("FAIL t3_strobes got=%0d exp=0", q_adr.size()); end
    checks++; if (upg_done_o !== 1'b1) begin failures++; $display("FAIL t3_done got=%b exp=1", upg_done_o); end
    checks++; if (upg_rst_o !== 1'b0) begin failures++; $display("FAIL t3_upg_rst got=%b exp=0", upg_rst_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL t3_err got=%b exp=0", err_o); end
  endtask

  task automatic test_bad_cmd();
    do_reset();
    send_ok(8'h7F);
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL t4_err got=%b exp=1", err_o); end
    checks++; if (upg_rst_o !== 1'b1) begin failures++; $display("FAIL t4_still_idle got=%b exp=1", upg_rst_o); end
    send_ok(8'h00); send_ok(8'h01); send_ok(8'h00);
    send_ok(8'h11); send_ok(8'h22); send_ok(8'h33); send_ok(8'h44);
    checks++;
    if (q_adr.size() != 1) begin
      failures++; $display("FAIL t4_strobes got=%0d exp=1", q_adr.size());
    end else begin
      checks++; if (q_adr[0] !== 15'h0000) begin failures++; $display("FAIL t4_adr got=%h exp=0000", q_adr[0]); end
      checks++; if (q_dat[0] !== 32'h44332211) begin failures++; $display("FAIL t4_dat got=%h exp=44332211", q_dat[0]); end
    end
    checks++; if (upg_done_o !== 1'b1) begin failures++; $display("FAIL t4_done got=%b exp=1", upg_done_o); end
  endtask

  task automatic test_frame_err();
    do_reset();
    send_ok(8'h00); send_ok(8'h01); send_ok(8'h00);
    send_ok(8'hAA); send_ok(8'hBB);
    send_byte(8'hCC, 1'b0);
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL t5_err got=%b exp=1", err_o); end
    checks++; if (upg_done_o !== 1'b0) begin failures++; $display("FAIL t5_done_early got=%b exp=0", upg_done_o); end
    send_ok(8'hCC); send_ok(8'hDD);
    checks++;
    if (q_adr.size() != 1) begin
      failures++; $display("FAIL t5_strobes got=%0d exp=1", q_adr.size());
    end else begin
      checks++; if (q_adr[0] !== 15'h0000) begin failures++; $display("FAIL t5_adr got=%h exp=0000", q_adr[0]); end
      checks++; if (q_dat[0] !== 32'hDDCCBBAA) begin failures++; $display("FAIL t5_dat got=%h exp=ddccbbaa", q_dat[0]); end
    end
  endtask

  task automatic test_midsession_reset();
    do_reset();
    send_ok(8'h01); send_ok(8'h02); send_ok(8'h00);
    send_ok(8'h01); send_ok(8'h02); send_ok(8'h03); send_ok(8'h04);
    send_ok(8'h05); send_ok(8'h06);
    checks++; if (q_adr.size() != 1) begin failures++; $display("FAIL t6_first_strobes got=%0d exp=1", q_adr.size()); end
    do_reset();
    checks++; if (upg_rst_o !== 1'b1) begin failures++; $display("FAIL t6_upg_rst got=%b exp=1", upg_rst_o); end
    checks++; if (upg_adr_o !== 15'h0000) begin failures++; $display("FAIL t6_adr_rst got=%h exp=0000", upg_adr_o); end
    checks++; if (upg_dat_o !== 32'h0) begin failures++; $display("FAIL t6_dat_rst got=%h exp=0", upg_dat_o); end
    checks++; if (upg_done_o !== 1'b0) begin failures++; $display("FAIL t6_done_rst got=%b exp=0", upg_done_o); end
    repeat (50) @(negedge clk);
    checks++; if (q_adr.size() != 0) begin failures++; $display("FAIL t6_no_strobe got=%0d exp=0", q_adr.size()); end
    send_ok(8'h00); send_ok(8'h01); send_ok(8'h00);
    send_ok(8'h78); send_ok(8'h56); send_ok(8'h34); send_ok(8'h12);
    checks++;
    if (q_adr.size() != 1) begin
      failures++; $display("FAIL t6_strobes got=%0d exp=1", q_adr.size());
    end else begin
      checks++; if (q_adr[0] !== 15'h0000) begin failures++; $display("FAIL t6_adr got=%h exp=0000", q_adr[0]); end
      checks++; if (q_dat[0] !== 32'h12345678) begin failures++; $display("FAIL t6_dat got=%h exp=12345678", q_dat[0]); end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    rx       = 1'b1;
    test_reset();
    test_single_word();
    test_multi_word();
    test_zero_len();
    test_bad_cmd();
    test_frame_err();
    test_midsession_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
